l2cache_wide_control: RTL and testbench

Sequencing FSM for the 4-way, 32-set, 256-bit-line L2 cache datapath (`l2cache_wide_datapath`). It accepts line-wide read/write requests from the L1 side and drives the datapath's array read, tag, valid, dirty, LRU and data-write controls. It runs writeback and fill handshakes to physical memory and keeps hit/miss/writeback counters. It sits beside the datapath inside the L2 top level, which also muxes `pmem_address` using `pmem_addr_sel`.

---
 rtl/l2cache_wide_control_pkg.sv | 23 ++
 rtl/l2cache_wide_control_cache_perf_counter.sv | 18 +
 rtl/l2cache_wide_control.sv | 183 ++++++++++++++++++
 tb/tb_l2cache_wide_control.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2cache_wide_control_pkg.sv
// Shared types and encodings for the wide L2 cache control slice.
package l2cache_types;

  typedef enum logic [2:0] {
    IDLE,
    TAG_CHECK,
    WRITE_BACK,
    FILL,
    REFILL_READ
  } l2wide_state_t;

  localparam logic [1:0] WSEL_NONE = 2'b00;
  localparam logic [1:0] WSEL_PMEM = 2'b01;
  localparam logic [1:0] WSEL_MEM  = 2'b10;

  localparam logic PADDR_MEM = 1'b0;
  localparam logic PADDR_WB  = 1'b1;

  function automatic logic [3:0] way_onehot(input logic [1:0] w);
    return 4'b0001 << w;
  endfunction

endpackage

// File: rtl/l2cache_wide_control_cache_perf_counter.sv
// Wrapping event counter with synchronous clear.
module cache_perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc)
      count <= count + W'(1);
  end

endmodule

// File: rtl/l2cache_wide_control.sv
// Sequencing FSM for the 4-way wide L2 datapath: tag check, writeback, fill
// and refill handshakes plus hit/miss/writeback counters.
module l2cache_wide_control
  import l2cache_types::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic             pmem_addr_sel,
  input  logic [3:0]       cache_hit,
  input  logic             write_back,
  input  logic [1:0]       way,
  input  logic [1:0]       way_reg,
  output logic             load_way_reg,
  output logic [3:0]       read_data_array,
  output logic [1:0]       way_sel,
  output logic [1:0]       write_sel,
  output logic [3:0]       load_tag,
  output logic [3:0]       load_valid,
  output logic [3:0]       load_dirty,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             load_lru,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  l2wide_state_t state, next_state;
  logic req_write;
  logic refilled;
  logic hit_inc, miss_inc, wb_inc;
  logic req, hit;

  // The victim/hit way comes in through way_reg; the raw way bus is not needed here.
  logic unused_way;
  assign unused_way = ^way;

  assign req = mem_read | mem_write;
  assign hit = |cache_hit;

  // The request type is latched so a dropped request still completes as issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_write <= 1'b0;
      refilled  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && req) begin
        req_write <= mem_write;
        refilled  <= 1'b0;
      end
      if (state == FILL && pmem_resp)
        refilled <= 1'b1;
    end
  end

  always_comb begin
    next_state      = state;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_addr_sel   = PADDR_MEM;
    load_way_reg    = 1'b0;
    read_data_array = 4'h0;
    way_sel         = 2'b00;
    write_sel       = WSEL_NONE;
    load_tag        = 4'h0;
    load_valid      = 4'h0;
    load_dirty      = 4'h0;
    set_valid       = 1'b0;
    set_dirty       = 1'b0;
    load_lru        = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    wb_inc          = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          read_data_array = 4'hF;
          load_way_reg    = 1'b1;
          next_state      = TAG_CHECK;
        end
      end
      TAG_CHECK: begin
        way_sel = way_reg;
        if (hit) begin
          load_lru   = 1'b1;
          mem_resp   = 1'b1;
          hit_inc    = ~refilled;
          next_state = IDLE;
          if (req_write) begin
            write_sel  = WSEL_MEM;
            load_dirty = way_onehot(way_reg);
            set_dirty  = 1'b1;
          end
        end else begin
          miss_inc   = 1'b1;
          next_state = write_back ? WRITE_BACK : FILL;
        end
      end
      WRITE_BACK: begin
        way_sel       = way_reg;
        pmem_addr_sel = PADDR_WB;
        pmem_write    = 1'b1;
        if (pmem_resp) begin
          load_dirty = way_onehot(way_reg);
          wb_inc     = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        way_sel   = way_reg;
        pmem_read = 1'b1;
        if (pmem_resp) begin
          write_sel  = WSEL_PMEM;
          load_tag   = way_onehot(way_reg);
          load_valid = way_onehot(way_reg);
          load_dirty = way_onehot(way_reg);
          set_valid  = 1'b1;
          next_state = REFILL_READ;
        end
      end
      REFILL_READ: begin
        read_data_array = 4'hF;
        load_way_reg    = 1'b1;
        next_state      = TAG_CHECK;
      end
      default: next_state = IDLE;
    endcase

    if (rst) begin
      mem_resp        = 1'b0;
      pmem_read       = 1'b0;
      pmem_write      = 1'b0;
      pmem_addr_sel   = PADDR_MEM;
      load_way_reg    = 1'b0;
      read_data_array = 4'h0;
      way_sel         = 2'b00;
      write_sel       = WSEL_NONE;
      load_tag        = 4'h0;
      load_valid      = 4'h0;
      load_dirty      = 4'h0;
      set_valid       = 1'b0;
      set_dirty       = 1'b0;
      load_lru        = 1'b0;
      hit_inc         = 1'b0;
      miss_inc        = 1'b0;
      wb_inc          = 1'b0;
    end
  end

  cache_perf_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  cache_perf_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

  cache_perf_counter #(.W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_inc),
    .count (wb_cnt)
  );

endmodule

// File: tb/tb_l2cache_wide_control.sv
// Transaction-level bench: each request is scripted cycle by cycle from the
// cache protocol rules and every cycle's outputs are compared to that script.
module tb_l2cache_wide_control;
  import l2cache_types::*;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write, mem_resp;
  logic          pmem_read, pmem_write, pmem_resp, pmem_addr_sel;
  logic [3:0]    cache_hit;
  logic          write_back;
  logic [1:0]    way, way_reg;
  logic          load_way_reg;
  logic [3:0]    read_data_array;
  logic [1:0]    way_sel, write_sel;
  logic [3:0]    load_tag, load_valid, load_dirty;
  logic          set_valid, set_dirty, load_lru;
  logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;

  l2cache_wide_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .pmem_addr_sel(pmem_addr_sel), .cache_hit(cache_hit),
    .write_back(write_back), .way(way), .way_reg(way_reg),
    .load_way_reg(load_way_reg), .read_data_array(read_data_array),
    .way_sel(way_sel), .write_sel(write_sel), .load_tag(load_tag),
    .load_valid(load_valid), .load_dirty(load_dirty), .set_valid(set_valid),
    .set_dirty(set_dirty), .load_lru(load_lru), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       resp, pread, pwrite, paddr, lwr;
    logic [3:0] rda;
    logic [1:0] wy, wsel;
    logic [3:0] ltag, lval, ldirty;
    logic       sval, sdirty, lru;
  } ov_t;

  ov_t  e;
  logic exp_valid = 1'b0;
  int   e_hit = 0, e_miss = 0, e_wb = 0;
  int   total = 0, passed = 0;
  int   cyc_n = 0, resp_cyc = -1, req_cyc = 0;

  always @(negedge clk) begin : compare
    ov_t a;
    a = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_way_reg,
         read_data_array, way_sel, write_sel, load_tag, load_valid, load_dirty,
         set_valid, set_dirty, load_lru};
    if (exp_valid) begin
      total++;
      if (a === e) passed++;
      else $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc_n, a, e);
      total++;
      if ({hit_cnt, miss_cnt, wb_cnt} === {CW'(e_hit), CW'(e_miss), CW'(e_wb)}) passed++;
      else $display("FAIL counters cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc_n,
                    hit_cnt, miss_cnt, wb_cnt, CW'(e_hit), CW'(e_miss), CW'(e_wb));
    end
    if (mem_resp === 1'b1) resp_cyc = cyc_n;
    cyc_n++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s got=%0d exp=%0d", name, act, expv);
  endtask

  task automatic junk();
    cache_hit  = 4'($urandom);
    write_back = 1'($urandom);
    way        = 2'($urandom);
    way_reg    = 2'($urandom);
    pmem_resp  = 1'($urandom);
  endtask

  // op: 0 read, 1 write, 2 both (treated as write)
  task automatic set_req(input int op, input int c, input int drop_at);
    if (drop_at > 0 && c >= drop_at) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end else begin
      mem_read  = (op != 1);
      mem_write = (op != 0);
    end
  endtask

  task automatic hit_exp(input bit wr, input logic [1:0] w);
    e.resp = 1'b1;
    e.lru  = 1'b1;
    if (wr) begin
      e.wsel   = WSEL_MEM;
      e.ldirty = way_onehot(w);
      e.sdirty = 1'b1;
    end
  endtask

  task automatic txn(input int op, input bit hit, input bit dirty, input logic [1:0] w,
                     input int kw, input int kf, input int drop_at);
    bit wr;
    int c;
    wr = (op != 0);
    c  = 0;
    junk(); set_req(op, c, drop_at);
    e = '0; e.rda = 4'hF; e.lwr = 1'b1;
    req_cyc = cyc_n;
    step(); c++;
    junk(); set_req(op, c, drop_at);
    way_reg = w; write_back = dirty; cache_hit = hit ? way_onehot(w) : 4'h0;
    e = '0; e.wy = w;
    if (hit) begin
      hit_exp(wr, w);
      step(); e_hit++;
    end else begin
      step(); e_miss++; c++;
      if (dirty) begin
        for (int j = 0; j <= kw; j++) begin
          junk(); set_req(op, c, drop_at);
          way_reg = w; pmem_resp = (j == kw);
          e = '0; e.wy = w; e.paddr = PADDR_WB; e.pwrite = 1'b1;
          if (j == kw) e.ldirty = way_onehot(w);
          step(); c++;
          if (j == kw) e_wb++;
        end
      end
      for (int j = 0; j <= kf; j++) begin
        junk(); set_req(op, c, drop_at);
        way_reg = w; pmem_resp = (j == kf);
        e = '0; e.wy = w; e.pread = 1'b1;
        if (j == kf) begin
          e.wsel = WSEL_PMEM;
          e.ltag = way_onehot(w); e.lval = way_onehot(w); e.ldirty = way_onehot(w);
          e.sval = 1'b1;
        end
        step(); c++;
      end
      junk(); set_req(op, c, drop_at);
      e = '0; e.rda = 4'hF; e.lwr = 1'b1;
      step(); c++;
      junk(); set_req(op, c, drop_at);
      way_reg = w; cache_hit = way_onehot(w);
      e = '0; e.wy = w; hit_exp(wr, w);
      step(); c++;
    end
    mem_read = 1'b0; mem_write = 1'b0; junk();
    e = '0;
    step();
  endtask

  task automatic reset_mid_fill(input logic [1:0] w);
    junk(); mem_read = 1'b1; mem_write = 1'b0;
    e = '0; e.rda = 4'hF; e.lwr = 1'b1;
    step();
    junk(); way_reg = w; cache_hit = 4'h0; write_back = 1'b0;
    e = '0; e.wy = w;
    step(); e_miss++;
    junk(); way_reg = w; pmem_resp = 1'b0;
    e = '0; e.wy = w; e.pread = 1'b1;
    step();
    junk(); way_reg = w; pmem_resp = 1'b0; rst = 1'b1;
    e = '0;
    step();
    e_hit = 0; e_miss = 0; e_wb = 0;
    rst = 1'b0; mem_read = 1'b0; junk(); pmem_resp = 1'b1;
    step();
    junk(); pmem_resp = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    cache_hit = 4'h0; write_back = 1'b0; way = 2'd0; way_reg = 2'd0; pmem_resp = 1'b0;
    e = '0;
    step();
    exp_valid = 1'b1;
    step();
    rst = 1'b0;
    step();

    // read hit in way 2
    txn(0, 1'b1, 1'b0, 2'd2, 0, 0, 0);
    check_lit("hit_latency", resp_cyc - req_cyc, 1);
    check_lit("hit_cnt", int'(hit_cnt), 1);
    // clean read miss, pmem_resp after 5 cycles of FILL
    txn(0, 1'b0, 1'b0, 2'd0, 0, 5, 0);
    check_lit("clean_miss_latency", resp_cyc - req_cyc, 9);
    check_lit("miss_cnt", int'(miss_cnt), 1);
    // dirty write miss
    txn(1, 1'b0, 1'b1, 2'd1, 2, 3, 0);
    check_lit("dirty_miss_latency", resp_cyc - req_cyc, 10);
    check_lit("wb_cnt", int'(wb_cnt), 1);
    // simultaneous read+write hit, then write miss with request dropped mid-FILL
    txn(2, 1'b1, 1'b0, 2'd3, 0, 0, 0);
    txn(1, 1'b0, 1'b0, 2'd1, 0, 3, 3);
    reset_mid_fill(2'd3);
    check_lit("miss_cnt_after_rst", int'(miss_cnt), 0);

    for (int n = 0; n < 200; n++) begin
      int  op, kw, kf, drop_at;
      bit  hit, dirty;
      op      = $urandom_range(0, 2);
      hit     = 1'($urandom_range(0, 1));
      dirty   = 1'($urandom_range(0, 1));
      kw      = $urandom_range(0, 4);
      kf      = $urandom_range(0, 4);
      drop_at = (!hit && $urandom_range(0, 3) == 0) ? $urandom_range(2, 4) : 0;
      txn(op, hit, dirty, 2'($urandom), kw, kf, drop_at);
      if ($urandom_range(0, 3) == 0) begin
        junk(); e = '0;
        step();
      end
    end

    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
